pipe_seq_ctrl: RTL
==================

// Module: pipe_seq_ctrl
// PURPOSE
//  Central sequencer for the 5-stage RV32 pipeline (IF/DE/EXE/ACC/WB). Owns the stage
//  enables and bubble injection: branch flush, load-use stall, data-memory wait with
//  timeout, and halt/drain on ECALL/EBREAK. Sits beside the operand-forwarding unit.
//  Stall and flush decisions made anywhere in the core are routed through this block.
// PARAMETERS
//  MEM_TIMEOUT  16  cycles in MEM_WAIT without dmem_ack before ERROR; 0 = no timeout
//  CNT_W        32  width of performance counters (PERF_CNT_EN only)
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  rst             in   1   asynchronous, active-low reset
//  de_rs1          in   5   rs1 field of instruction in DE
//  de_rs2          in   5   rs2 field of instruction in DE
//  de_use_rs1      in   1   DE instruction reads rs1
//  de_use_rs2      in   1   DE instruction reads rs2
//  de_halt         in   1   DE holds ECALL/EBREAK
//  exe_rd          in   5   rd of instruction in EXE
//  exe_is_load     in   1   EXE holds a load (opcode 0000011)
//  exe_br_taken    in   1   EXE resolved a taken branch/JAL/JALR
//  acc_mem_req     in   1   ACC instruction accesses dmem this cycle
//  dmem_ack        in   1   dmem completes ACC access this cycle
//  resume          in   1   leave HALTED (pulse)
//  pc_en,de_en,exe_en,acc_en,wb_en  out 1 each  stage register load enables
//  flush_de        out  1   load NOP into DE register
//  flush_exe       out  1   load NOP into EXE register
//  halted          out  1   core drained and stopped
//  mem_err         out  1   dmem timeout; sticky until reset
// BEHAVIOUR
//  - States: RUN, MEM_WAIT, DRAIN, HALTED, ERROR. State reg + 5-bit wait_cnt + 2-bit drain_cnt.
//  - rst low: state=RUN, counters=0; outputs forced: all *_en=0, flush_de=flush_exe=1,
//    halted=0, mem_err=0. Outputs otherwise combinational from state + inputs (0 latency).
//  - RUN, per-cycle priority (first match wins):
//    1 acc_mem_req & !dmem_ack: all *_en=0 except wb_en=0 too (WB bubble); ->MEM_WAIT, wait_cnt=1.
//    2 exe_br_taken: all *_en=1, flush_de=flush_exe=1; stay RUN (branch wins over load-use/halt).
//    3 load-use: exe_is_load & exe_rd!=0 & ((de_use_rs1&de_rs1==exe_rd)|(de_use_rs2&de_rs2==exe_rd)):
//      pc_en=de_en=0, flush_exe=1, exe/acc/wb_en=1; exactly one bubble; stay RUN.
//    4 de_halt: pc_en=0, flush_de=1, others 1; ->DRAIN, drain_cnt=0.
//    5 else all *_en=1, no flush.
//  - MEM_WAIT: all *_en=0, no flush. dmem_ack: all *_en=1 this cycle, ->RUN.
//    No ack & MEM_TIMEOUT!=0 & wait_cnt==MEM_TIMEOUT-1: ->ERROR. Else wait_cnt++.
//    exe_br_taken/load-use held frozen; they are evaluated again in RUN.
//  - DRAIN: pc_en=0, flush_de=1, exe/acc/wb_en=1 (halt instr retires); drain_cnt++;
//    at drain_cnt==2 ->HALTED. acc_mem_req&!dmem_ack in DRAIN freezes drain_cnt, all en=0.
//  - HALTED: all *_en=0, halted=1. resume: ->RUN next cycle (pc_en=1 from then).
//  - ERROR: all *_en=0, mem_err=1; exits only via rst.
//  - rst asserted mid-operation: immediate return to reset outputs, no pending state kept.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: adds outputs stall_cnt[CNT_W-1:0] (cycles with pc_en=0 while in
//  RUN/MEM_WAIT/DRAIN) and flush_cnt[CNT_W-1:0] (cycles with flush_exe=1); both reset to 0,
//  wrap at 2^CNT_W. Not defined: ports and counters absent; control behaviour identical.
// TESTING
//  - load x5 in EXE, DE add reads x5 -> one cycle pc_en=de_en=0, flush_exe=1; next cycle all en=1.
//  - load x0 in EXE, DE reads x0 -> no stall; exe_br_taken + load-use same cycle -> flushes only, pc_en=1.
//  - acc_mem_req, dmem_ack after 3 cycles -> 3 cycles all en=0, ack cycle all en=1, then RUN.
//  - acc_mem_req, no ack, MEM_TIMEOUT=16 -> mem_err=1 on cycle 16, stays until rst low.
//  - de_halt -> 3 DRAIN cycles pc_en=0, then halted=1; resume pulse -> halted=0, pc_en=1.
//  - rst low during MEM_WAIT -> outputs at reset values at once; RUN after release.

Source files
------------

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencer for the 5-stage RV32 core: stage enables, bubbles, dmem wait/timeout, halt/drain.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_seq_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       de_rs1,
  input  logic [4:0]       de_rs2,
  input  logic             de_use_rs1,
  input  logic             de_use_rs2,
  input  logic             de_halt,
  input  logic [4:0]       exe_rd,
  input  logic             exe_is_load,
  input  logic             exe_br_taken,
  input  logic             acc_mem_req,
  input  logic             dmem_ack,
  input  logic             resume,
  output logic             pc_en,
  output logic             de_en,
  output logic             exe_en,
  output logic             acc_en,
  output logic             wb_en,
  output logic             flush_de,
  output logic             flush_exe,
  output logic             halted,
  output logic             mem_err,
  output logic [2:0]       dbg_state
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [2:0] {
    S_RUN      = 3'd0,
    S_MEM_WAIT = 3'd1,
    S_DRAIN    = 3'd2,
    S_HALTED   = 3'd3,
    S_ERROR    = 3'd4
  } state_t;

  // Last wait_cnt value before giving up on dmem (only meaningful when MEM_TIMEOUT != 0).
  localparam logic [4:0] TO_LAST = (MEM_TIMEOUT > 0) ? 5'(MEM_TIMEOUT - 1) : 5'd0;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [4:0] r_wait_cnt;
  logic [4:0] w_wait_cnt_nxt;
  logic [1:0] r_drain_cnt;
  logic [1:0] w_drain_cnt_nxt;

  logic w_mem_stall;
  logic w_load_use;
  logic w_pc_en;
  logic w_de_en;
  logic w_exe_en;
  logic w_acc_en;
  logic w_wb_en;
  logic w_flush_de;
  logic w_flush_exe;
  logic w_halted;
  logic w_mem_err;

  assign w_mem_stall = acc_mem_req & ~dmem_ack;
  assign w_load_use  = exe_is_load & (exe_rd != 5'd0) &
                       ((de_use_rs1 & (de_rs1 == exe_rd)) |
                        (de_use_rs2 & (de_rs2 == exe_rd)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= 5'd0;
      r_drain_cnt <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_drain_cnt_nxt = r_drain_cnt;
    w_pc_en         = 1'b0;
    w_de_en         = 1'b0;
    w_exe_en        = 1'b0;
    w_acc_en        = 1'b0;
    w_wb_en         = 1'b0;
    w_flush_de      = 1'b0;
    w_flush_exe     = 1'b0;
    w_halted        = 1'b0;
    w_mem_err       = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_mem_stall) begin
          w_state_nxt    = S_MEM_WAIT;
          w_wait_cnt_nxt = 5'd1;
        end else if (exe_br_taken) begin
          // Branch outranks load-use and halt: the younger instructions are discarded anyway.
          {w_pc_en, w_de_en, w_exe_en, w_acc_en, w_wb_en} = 5'b11111;
          w_flush_de  = 1'b1;
          w_flush_exe = 1'b1;
        end else if (w_load_use) begin
          {w_exe_en, w_acc_en, w_wb_en} = 3'b111;
          w_flush_exe = 1'b1;
        end else if (de_halt) begin
          {w_de_en, w_exe_en, w_acc_en, w_wb_en} = 4'b1111;
          w_flush_de      = 1'b1;
          w_state_nxt     = S_DRAIN;
          w_drain_cnt_nxt = 2'd0;
        end else begin
          {w_pc_en, w_de_en, w_exe_en, w_acc_en, w_wb_en} = 5'b11111;
        end
      end
      S_MEM_WAIT: begin
        if (dmem_ack) begin
          {w_pc_en, w_de_en, w_exe_en, w_acc_en, w_wb_en} = 5'b11111;
          w_state_nxt    = S_RUN;
          w_wait_cnt_nxt = 5'd0;
        end else if ((MEM_TIMEOUT != 0) && (r_wait_cnt >= TO_LAST)) begin
          w_state_nxt = S_ERROR;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 5'd1;
        end
      end
      S_DRAIN: begin
        // A dmem stall while draining freezes the whole pipe and the drain count with it.
        if (!w_mem_stall) begin
          {w_de_en, w_exe_en, w_acc_en, w_wb_en} = 4'b1111;
          w_flush_de = 1'b1;
          if (r_drain_cnt == 2'd2) begin
            w_state_nxt = S_HALTED;
          end else begin
            w_drain_cnt_nxt = r_drain_cnt + 2'd1;
          end
        end
      end
      S_HALTED: begin
        w_halted = 1'b1;
        if (resume) begin
          w_state_nxt = S_RUN;
        end
      end
      S_ERROR: begin
        w_mem_err = 1'b1;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  // Reset overrides the outputs combinationally so the pipe is frozen and flushed at once.
  always_comb begin
    if (!rst) begin
      {pc_en, de_en, exe_en, acc_en, wb_en} = 5'b00000;
      flush_de  = 1'b1;
      flush_exe = 1'b1;
      halted    = 1'b0;
      mem_err   = 1'b0;
    end else begin
      pc_en     = w_pc_en;
      de_en     = w_de_en;
      exe_en    = w_exe_en;
      acc_en    = w_acc_en;
      wb_en     = w_wb_en;
      flush_de  = w_flush_de;
      flush_exe = w_flush_exe;
      halted    = w_halted;
      mem_err   = w_mem_err;
    end
  end

  assign dbg_state = r_state;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall_state;

  assign w_stall_state = (r_state == S_RUN) || (r_state == S_MEM_WAIT) || (r_state == S_DRAIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc_en && w_stall_state) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush_exe) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule
